// File: rtl/mips_instr_encoder.sv
// Encodes compact mnemonic/operand commands into 32-bit MIPS words and streams
// them, tagged with a byte address, to the instruction-memory loader.
module mips_instr_encoder #(
  parameter int                ADDR_W    = 32,
  parameter logic [ADDR_W-1:0] BASE_ADDR = '0
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              addr_clr,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [4:0]        in_mnem,
  input  logic [4:0]        in_rs,
  input  logic [4:0]        in_rt,
  input  logic [4:0]        in_rd,
  input  logic [4:0]        in_shamt,
  input  logic [31:0]       in_imm,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [31:0]       out_instr,
  output logic [ADDR_W-1:0] out_addr,
  output logic              err,
  output logic              dbg_state
);

  // Handshake: a beat moves on either side only in a cycle where valid and
  // ready are both high; valid never depends on ready, and a presented word
  // (out_instr/out_addr) holds until it is taken.

  typedef enum logic {IDLE = 1'b0, LI_LO = 1'b1} state_t;

  localparam logic [4:0] M_LI = 5'd29;
  localparam logic [5:0] OP_ORI = 6'b001101;
  localparam logic [5:0] OP_LUI = 6'b001111;

  state_t            state;
  logic [ADDR_W-1:0] addr_q;
  logic [4:0]        li_rt;
  logic [15:0]       li_lo;
  logic              accept;
  logic              out_hs;
  logic              illegal;

  function automatic logic [31:0] encode(input logic [4:0] mnem, input logic [4:0] rs,
                                         input logic [4:0] rt, input logic [4:0] rd,
                                         input logic [4:0] shamt, input logic [31:0] imm);
    logic [5:0]  f;
    logic [5:0]  op;
    logic [4:0]  s;
    logic [4:0]  t;
    logic [4:0]  d;
    logic [4:0]  sa;
    logic [31:0] w;
    f  = 6'b000000;
    op = 6'b000000;
    s  = rs;
    t  = rt;
    d  = rd;
    sa = 5'd0;
    case (mnem)
      5'd1:  f = 6'b100000;
      5'd2:  f = 6'b100001;
      5'd3:  f = 6'b100010;
      5'd4:  f = 6'b100100;
      5'd5:  f = 6'b100101;
      5'd6:  f = 6'b100111;
      5'd7:  f = 6'b101010;
      5'd8:  f = 6'b101011;
      5'd9:  begin f = 6'b000000; s = 5'd0; sa = shamt; end
      5'd10: begin f = 6'b000010; s = 5'd0; sa = shamt; end
      5'd11: begin f = 6'b000011; s = 5'd0; sa = shamt; end
      5'd12: f = 6'b000100;
      5'd13: f = 6'b000111;
      5'd14: begin f = 6'b001000; t = 5'd0; d = 5'd0; end
      5'd15: begin f = 6'b001100; s = 5'd0; t = 5'd0; d = 5'd0; end
      5'd16: op = 6'b001000;
      5'd17: op = 6'b001001;
      5'd18: op = 6'b001100;
      5'd19: op = OP_ORI;
      5'd20: op = 6'b001010;
      5'd21: begin op = OP_LUI; s = 5'd0; end
      5'd22: op = 6'b100011;
      5'd23: op = 6'b101011;
      5'd24: op = 6'b101001;
      5'd25: op = 6'b000100;
      5'd26: op = 6'b000101;
      5'd27: op = 6'b000010;
      5'd28: op = 6'b000011;
      default: ;
    endcase
    if (mnem == 5'd0 || mnem >= M_LI)
      w = 32'h0;
    else if (mnem < 5'd16)
      w = {6'b000000, s, t, d, sa, f};
    else if (mnem == 5'd27 || mnem == 5'd28)
      w = {op, imm[25:0]};
    else
      w = {op, s, t, imm[15:0]};
    return w;
  endfunction

  assign in_ready  = (state == IDLE) && (!out_valid || out_ready);
  assign accept    = in_valid && in_ready;
  assign out_hs    = out_valid && out_ready;
  assign illegal   = (in_mnem > M_LI);
  assign out_addr  = addr_q;
  assign dbg_state = state;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      addr_q    <= BASE_ADDR;
      out_valid <= 1'b0;
      out_instr <= 32'h0;
      err       <= 1'b0;
      li_rt     <= 5'd0;
      li_lo     <= 16'h0;
    end else begin
      err <= 1'b0;
      // A clear takes precedence over the advance of a completing word.
      if (addr_clr)
        addr_q <= BASE_ADDR;
      else if (out_hs)
        addr_q <= addr_q + ADDR_W'(4);

      if (state == LI_LO) begin
        if (out_hs) begin
          out_instr <= {OP_ORI, li_rt, li_rt, li_lo};
          out_valid <= 1'b1;
          state     <= IDLE;
        end
      end else begin
        if (out_hs)
          out_valid <= 1'b0;
        if (accept) begin
          if (illegal) begin
            err <= 1'b1;
          end else if (in_mnem == M_LI) begin
            out_valid <= 1'b1;
            if (in_imm[31:16] == 16'h0) begin
              out_instr <= {OP_ORI, 5'd0, in_rt, in_imm[15:0]};
            end else begin
              out_instr <= {OP_LUI, 5'd0, in_rt, in_imm[31:16]};
              li_rt     <= in_rt;
              li_lo     <= in_imm[15:0];
              state     <= LI_LO;
            end
          end else begin
            out_valid <= 1'b1;
            out_instr <= encode(in_mnem, in_rs, in_rt, in_rd, in_shamt, in_imm);
          end
        end
      end
    end
  end

endmodule

// File: tb/tb_mips_instr_encoder.sv
// Directed bench for mips_instr_encoder: hand-computed words, addresses and
// handshake behaviour checked with immediate assertions.
module tb_mips_instr_encoder;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        addr_clr;
  logic        in_valid;
  logic        in_ready;
  logic [4:0]  in_mnem;
  logic [4:0]  in_rs;
  logic [4:0]  in_rt;
  logic [4:0]  in_rd;
  logic [4:0]  in_shamt;
  logic [31:0] in_imm;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_instr;
  logic [31:0] out_addr;
  logic        err;
  logic        dbg_state;

  int n_total = 0;
  int n_pass  = 0;

  // clock / reset
  always #5 clk = ~clk;

  mips_instr_encoder #(.ADDR_W(32), .BASE_ADDR(32'h0)) dut (
    .clk(clk), .rst_n(rst_n), .addr_clr(addr_clr),
    .in_valid(in_valid), .in_ready(in_ready), .in_mnem(in_mnem),
    .in_rs(in_rs), .in_rt(in_rt), .in_rd(in_rd), .in_shamt(in_shamt), .in_imm(in_imm),
    .out_valid(out_valid), .out_ready(out_ready), .out_instr(out_instr),
    .out_addr(out_addr), .err(err), .dbg_state(dbg_state)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
  endtask

  task automatic step();
    @(negedge clk);
  endtask

  task automatic beat(input logic [4:0] m, input logic [4:0] rs, input logic [4:0] rt,
                      input logic [4:0] rd, input logic [4:0] sh, input logic [31:0] imm);
    in_valid = 1'b1;
    in_mnem  = m;
    in_rs    = rs;
    in_rt    = rt;
    in_rd    = rd;
    in_shamt = sh;
    in_imm   = imm;
  endtask

  task automatic idle_in();
    in_valid = 1'b0;
  endtask

  task automatic clr_addr();
    addr_clr = 1'b1;
    step();
    addr_clr = 1'b0;
  endtask

  initial begin
    rst_n = 1'b0; addr_clr = 1'b0; out_ready = 1'b0;
    in_valid = 1'b0; in_mnem = '0; in_rs = '0; in_rt = '0; in_rd = '0;
    in_shamt = '0; in_imm = '0;
    step(); step();
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_out_instr", out_instr, 32'h0);
    chk("rst_out_addr", out_addr, 32'h0);
    chk("rst_err", 32'(err), 32'd0);
    rst_n = 1'b1;
    step();
    chk("post_rst_in_ready", 32'(in_ready), 32'd1);

    // add rs=1 rt=2 rd=3, held by out_ready=0
    beat(5'd1, 5'd1, 5'd2, 5'd3, 5'd9, 32'h0);
    step();
    idle_in();
    chk("add_valid", 32'(out_valid), 32'd1);
    chk("add_instr", out_instr, 32'h00221820);
    chk("add_addr", out_addr, 32'h0);
    chk("add_stall_in_ready", 32'(in_ready), 32'd0);
    out_ready = 1'b1;
    step();
    chk("add_drained", 32'(out_valid), 32'd0);
    chk("add_next_addr", out_addr, 32'h4);

    // lw then j back-to-back
    clr_addr();
    chk("clr_addr", out_addr, 32'h0);
    beat(5'd22, 5'd29, 5'd8, 5'd0, 5'd0, 32'h0000_0004);
    step();
    chk("lw_instr", out_instr, 32'h8FA80004);
    chk("lw_addr", out_addr, 32'h0);
    chk("lw_in_ready", 32'(in_ready), 32'd1);
    beat(5'd27, 5'd0, 5'd0, 5'd0, 5'd0, 32'h0000_0040);
    step();
    idle_in();
    chk("j_valid", 32'(out_valid), 32'd1);
    chk("j_instr", out_instr, 32'h08000040);
    chk("j_addr", out_addr, 32'h4);
    step();
    chk("j_drained", 32'(out_valid), 32'd0);
    chk("j_next_addr", out_addr, 32'h8);

    // li with a high half: lui then ori
    clr_addr();
    beat(5'd29, 5'd0, 5'd4, 5'd0, 5'd0, 32'h1234_5678);
    step();
    idle_in();
    chk("li_lui_instr", out_instr, 32'h3C041234);
    chk("li_lui_addr", out_addr, 32'h0);
    chk("li_lo_in_ready", 32'(in_ready), 32'd0);
    chk("li_lo_state", 32'(dbg_state), 32'd1);
    step();
    chk("li_ori_valid", 32'(out_valid), 32'd1);
    chk("li_ori_instr", out_instr, 32'h34845678);
    chk("li_ori_addr", out_addr, 32'h4);
    step();
    chk("li_drained", 32'(out_valid), 32'd0);
    chk("li_next_addr", out_addr, 32'h8);

    // li with a zero high half: single ori
    beat(5'd29, 5'd0, 5'd4, 5'd0, 5'd0, 32'h0000_0010);
    step();
    idle_in();
    chk("li1_instr", out_instr, 32'h34040010);
    chk("li1_addr", out_addr, 32'h8);
    step();
    chk("li1_single", 32'(out_valid), 32'd0);
    chk("li1_next_addr", out_addr, 32'hC);

    // stall three cycles with a second beat waiting
    out_ready = 1'b0;
    beat(5'd3, 5'd5, 5'd6, 5'd7, 5'd0, 32'h0);
    step();
    beat(5'd9, 5'd9, 5'd1, 5'd2, 5'd4, 32'h0);
    for (int i = 0; i < 3; i++) begin
      chk("stall_instr", out_instr, 32'h00A63822);
      chk("stall_addr", out_addr, 32'hC);
      chk("stall_in_ready", 32'(in_ready), 32'd0);
      step();
    end
    out_ready = 1'b1;
    step();
    idle_in();
    chk("sll_valid", 32'(out_valid), 32'd1);
    chk("sll_instr", out_instr, 32'h00011100);
    chk("sll_addr", out_addr, 32'h10);
    step();
    chk("sll_drained", 32'(out_valid), 32'd0);
    chk("sll_next_addr", out_addr, 32'h14);

    // illegal mnemonic
    beat(5'd30, 5'd1, 5'd1, 5'd1, 5'd1, 32'hFFFF_FFFF);
    step();
    idle_in();
    chk("ill_err", 32'(err), 32'd1);
    chk("ill_no_valid", 32'(out_valid), 32'd0);
    chk("ill_addr", out_addr, 32'h14);
    step();
    chk("ill_err_pulse", 32'(err), 32'd0);
    chk("ill_addr_hold", out_addr, 32'h14);

    // field forcing (nop, jr, syscall) and addr_clr racing a handshake at 8
    clr_addr();
    beat(5'd0, 5'd3, 5'd3, 5'd3, 5'd3, 32'hFFFF_FFFF);
    step();
    chk("nop_instr", out_instr, 32'h0);
    chk("nop_addr", out_addr, 32'h0);
    beat(5'd14, 5'd31, 5'd5, 5'd6, 5'd7, 32'h0);
    step();
    chk("jr_instr", out_instr, 32'h03E00008);
    chk("jr_addr", out_addr, 32'h4);
    beat(5'd15, 5'd1, 5'd2, 5'd3, 5'd4, 32'h0);
    step();
    idle_in();
    chk("syscall_instr", out_instr, 32'h0000000C);
    chk("syscall_addr", out_addr, 32'h8);
    addr_clr = 1'b1;
    step();
    addr_clr = 1'b0;
    chk("clr_hs_drained", 32'(out_valid), 32'd0);
    chk("clr_hs_addr", out_addr, 32'h0);

    // reset after the lui half of a li
    out_ready = 1'b0;
    beat(5'd29, 5'd0, 5'd4, 5'd0, 5'd0, 32'h1234_5678);
    step();
    idle_in();
    chk("rli_lui_instr", out_instr, 32'h3C041234);
    rst_n = 1'b0;
    #1;
    chk("rli_valid", 32'(out_valid), 32'd0);
    chk("rli_addr", out_addr, 32'h0);
    chk("rli_state", 32'(dbg_state), 32'd0);
    step();
    rst_n = 1'b1;
    out_ready = 1'b1;
    step();
    chk("rli_no_ori_1", 32'(out_valid), 32'd0);
    step();
    chk("rli_no_ori_2", 32'(out_valid), 32'd0);
    chk("rli_in_ready", 32'(in_ready), 32'd1);
    chk("rli_addr_after", out_addr, 32'h0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
